// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch/decode boundary: state encoding, word type
// and the stall-window counter helpers.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [2:0]  stall_cnt_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_HOLD = 2'd1,
        JU_FILL = 2'd2
    } ifid_state_t;

    localparam word_t NOP_INSTR = 32'h0;

    // Terminal count value for a window length, truncated to the counter width.
    function automatic stall_cnt_t cnt_of(input int unsigned value);
        return stall_cnt_t'(value);
    endfunction

endpackage

// File: rtl/stall_timer.sv
// 3-bit stall window counter with clear/start/increment controls and
// terminal-compare flags for the load-use and branch windows.
module stall_timer
    import cpu_types_pkg::*;
#(
    parameter int unsigned LU_CYCLES = 2,
    parameter int unsigned JU_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       en,
    input  logic       clear,
    input  logic       start,
    input  logic       inc,
    output stall_cnt_t count,
    output logic       lu_term,
    output logic       ju_term
);

    localparam stall_cnt_t LU_TERM = cnt_of(LU_CYCLES);
    localparam stall_cnt_t JU_TERM = cnt_of(JU_CYCLES - 1);

    // Counter update; clear beats start beats increment, all gated by en.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= 3'd0;
        end else if (en) begin
            if (clear) begin
                count <= 3'd0;
            end else if (start) begin
                count <= 3'd1;
            end else if (inc) begin
                count <= count + 3'd1;
            end
        end
    end

    assign lu_term = (count == LU_TERM);
    assign ju_term = (count == JU_TERM);

endmodule

// File: rtl/ifid_stall_latch.sv
// IF/ID pipeline register with load-use / branch stall sequencing, PC gating,
// ID/EX bubble request and same-cycle done pulses back to the hazard unit.
module ifid_stall_latch
    import cpu_types_pkg::*;
#(
    parameter int unsigned LU_CYCLES = 2,
    parameter int unsigned JU_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        advance,
    input  logic        halt,
    input  logic        flush,
    input  logic        load_use,
    input  logic        jump_use,
    input  logic [31:0] imemload,
    input  logic [31:0] npc,
    output logic [31:0] instr_id,
    output logic [31:0] npc_id,
    output logic        valid_id,
    output logic        pc_en,
    output logic        bubble_ex,
    output logic        flag_lu_done,
    output logic        flag_ju_done
);

    ifid_state_t state;
    stall_cnt_t  count;
    logic        step;
    logic        lu_term;
    logic        ju_term;
    logic        timer_clear;
    logic        timer_start;
    logic        timer_inc;

    assign step = advance & ~halt;

    stall_timer #(
        .LU_CYCLES (LU_CYCLES),
        .JU_CYCLES (JU_CYCLES)
    ) u_timer (
        .CLK     (CLK),
        .nRST    (nRST),
        .en      (step),
        .clear   (timer_clear),
        .start   (timer_start),
        .inc     (timer_inc),
        .count   (count),
        .lu_term (lu_term),
        .ju_term (ju_term)
    );

    // PC gate, bubble request, done pulses and counter controls.
    always_comb begin
        pc_en        = 1'b0;
        bubble_ex    = 1'b0;
        flag_lu_done = 1'b0;
        flag_ju_done = 1'b0;
        timer_clear  = 1'b0;
        timer_start  = 1'b0;
        timer_inc    = 1'b0;
        if (halt) begin
            pc_en = 1'b0;
        end else if (flush && advance) begin
            pc_en        = 1'b1;
            timer_clear  = 1'b1;
            flag_lu_done = (state == LU_HOLD);
            flag_ju_done = (state == JU_FILL);
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        bubble_ex   = 1'b1;
                        timer_start = 1'b1;
                    end else begin
                        pc_en       = advance;
                        timer_clear = 1'b1;
                    end
                end
                LU_HOLD: begin
                    bubble_ex = 1'b1;
                    if (lu_term) begin
                        flag_lu_done = advance;
                        timer_clear  = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
                JU_FILL: begin
                    if (ju_term) begin
                        flag_ju_done = advance;
                        timer_clear  = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
                default: begin
                    timer_clear = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state and IF/ID contents; only an unhalted advance moves them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= RUN;
            instr_id <= NOP_INSTR;
            npc_id   <= 32'h0;
            valid_id <= 1'b0;
        end else if (step) begin
            if (flush) begin
                state    <= RUN;
                instr_id <= NOP_INSTR;
                valid_id <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (load_use) begin
                            state <= LU_HOLD;
                        end else begin
                            instr_id <= imemload;
                            npc_id   <= npc;
                            valid_id <= 1'b1;
                            if (jump_use) begin
                                state <= JU_FILL;
                            end
                        end
                    end
                    LU_HOLD: begin
                        if (lu_term) begin
                            instr_id <= imemload;
                            npc_id   <= npc;
                            valid_id <= 1'b1;
                            state    <= RUN;
                        end
                    end
                    JU_FILL: begin
                        instr_id <= NOP_INSTR;
                        valid_id <= 1'b0;
                        if (ju_term) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifid_stall_latch.sv
// Scoreboard bench for ifid_stall_latch: a window-countdown reference model
// predicts every output each cycle; predictions are queued and compared.
module tb_ifid_stall_latch;

    localparam int LU = 2;
    localparam int JU = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        advance = 1'b0;
    logic        halt = 1'b0;
    logic        flush = 1'b0;
    logic        load_use = 1'b0;
    logic        jump_use = 1'b0;
    logic [31:0] imemload = 32'h0;
    logic [31:0] npc = 32'h0;
    logic [31:0] instr_id;
    logic [31:0] npc_id;
    logic        valid_id;
    logic        pc_en;
    logic        bubble_ex;
    logic        flag_lu_done;
    logic        flag_ju_done;

    ifid_stall_latch #(.LU_CYCLES(LU), .JU_CYCLES(JU)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .advance      (advance),
        .halt         (halt),
        .flush        (flush),
        .load_use     (load_use),
        .jump_use     (jump_use),
        .imemload     (imemload),
        .npc          (npc),
        .instr_id     (instr_id),
        .npc_id       (npc_id),
        .valid_id     (valid_id),
        .pc_en        (pc_en),
        .bubble_ex    (bubble_ex),
        .flag_lu_done (flag_lu_done),
        .flag_ju_done (flag_ju_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        pc;
        logic        bub;
        logic        lud;
        logic        jud;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model: 0=run, 1=load-use hold, 2=branch fill; rem = window cycles left.
    int          m_st;
    int          m_rem;
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    logic        m_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_st = 0; m_rem = 0; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
    endtask

    task automatic cycle(input logic adv, input logic hlt, input logic fl, input logic lu,
                         input logic ju, input logic [31:0] im, input logic [31:0] np);
        exp_t e;
        exp_t got;
        @(posedge CLK); #1;
        advance = adv; halt = hlt; flush = fl; load_use = lu; jump_use = ju;
        imemload = im; npc = np;
        e.instr = m_instr; e.npc = m_npc; e.valid = m_valid;
        e.pc = 1'b0; e.bub = 1'b0; e.lud = 1'b0; e.jud = 1'b0;
        if (hlt) begin
        end else if (fl && adv) begin
            e.pc = 1'b1; e.lud = (m_st == 1); e.jud = (m_st == 2);
        end else if (m_st == 0) begin
            if (lu) e.bub = 1'b1;
            else e.pc = adv;
        end else if (m_st == 1) begin
            e.bub = 1'b1; e.lud = adv && (m_rem == 1);
        end else begin
            e.jud = adv && (m_rem == 1);
        end
        sb.push_back(e);
        @(negedge CLK);
        got = sb.pop_front();
        check_eq("instr_id", instr_id, got.instr);
        check_eq("npc_id", npc_id, got.npc);
        check_eq("valid_id", {31'h0, valid_id}, {31'h0, got.valid});
        check_eq("pc_en", {31'h0, pc_en}, {31'h0, got.pc});
        check_eq("bubble_ex", {31'h0, bubble_ex}, {31'h0, got.bub});
        check_eq("flag_lu_done", {31'h0, flag_lu_done}, {31'h0, got.lud});
        check_eq("flag_ju_done", {31'h0, flag_ju_done}, {31'h0, got.jud});
        if (adv && !hlt) begin
            if (fl) begin
                m_instr = 32'h0; m_valid = 1'b0; m_st = 0; m_rem = 0;
            end else if (m_st == 0) begin
                if (lu) begin
                    m_st = 1; m_rem = LU;
                end else begin
                    m_instr = im; m_npc = np; m_valid = 1'b1;
                    if (ju) begin m_st = 2; m_rem = JU; end
                end
            end else if (m_st == 1) begin
                if (m_rem == 1) begin
                    m_instr = im; m_npc = np; m_valid = 1'b1; m_st = 0;
                end else m_rem--;
            end else begin
                m_instr = 32'h0; m_valid = 1'b0;
                if (m_rem == 1) m_st = 0;
                else m_rem--;
            end
        end
    endtask

    initial begin
        model_reset();
        #12 nRST = 1'b1;

        // reset state, then plain fetch
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8C220004, 32'h4);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00221820, 32'h8);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000020, 32'hC);

        // load-use, advancing every cycle; request held until released
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00431020, 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00431020, 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00431020, 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00642024, 32'h14);

        // branch in fetch: beq latched, then two NOPs
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10220003, 32'h18);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 32'h1C);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 32'h20);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33333333, 32'h28);

        // load-use window stretched by three stalled cycles
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, 32'h2C);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, 32'h2C);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, 32'h2C);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, 32'h2C);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hBBBB0002, 32'h30);

        // flush during branch fill, and halt freezing a load-use window
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10220003, 32'h34);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCCCC0003, 32'h38);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDDDD0004, 32'h80);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hEEEE0005, 32'h84);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hEEEE0005, 32'h84);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hEEEE0005, 32'h84);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF0006, 32'h90);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h94);

        // reset asserted in the middle of a load-use window
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0BADF00D, 32'h98);
        @(posedge CLK); #2;
        advance = 1'b0; load_use = 1'b0; nRST = 1'b0;
        #1;
        check_eq("rst_instr_id", instr_id, 32'h0);
        check_eq("rst_npc_id", npc_id, 32'h0);
        check_eq("rst_valid_id", {31'h0, valid_id}, 32'h0);
        check_eq("rst_bubble_ex", {31'h0, bubble_ex}, 32'h0);
        check_eq("rst_lu_done", {31'h0, flag_lu_done}, 32'h0);
        check_eq("rst_ju_done", {31'h0, flag_ju_done}, 32'h0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00221820, 32'hA0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8C220004, 32'hA4);

        // randomized traffic against the model
        for (int i = 0; i < 80; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom, $urandom);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
